// File: rtl/cpu_cycle_controller.sv
// Multi-cycle sequencer: steps each instruction through FETCH/EXEC/MEM/WB and
// issues the registered commit enables for the datapath.
module cpu_cycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned RETIRE_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          inst_class,
    input  logic [3:0]          opcode,
    input  logic                s_bit,
    input  logic                link_bit,
    input  logic                cond_pass,
    input  logic                mem_ready,
    input  logic                halt_req,
    output logic [1:0]          phase,
    output logic                inst_we,
    output logic                pc_we,
    output logic                pc_branch,
    output logic                rf_we,
    output logic                flags_we,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_err,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired
);

    // Wait counter runs 0 .. MEM_TIMEOUT-1 inside one MEM phase.
    localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {StFetch, StExec, StMem, StWb, StHalt} state_e;

    state_e              state_q, state_d;
    logic [WaitW-1:0]    wait_q, wait_d;
    logic [2:0]          cls_q, cls_d;
    logic [3:0]          opc_q, opc_d;
    logic                s_q, s_d;
    logic                link_q, link_d;
    logic                cond_q, cond_d;
    logic                timeout;
    logic                is_dp, is_ls, is_br, is_test, mem_active;

    logic [1:0]          phase_q, phase_d;
    logic                inst_we_q, pc_we_q, pc_branch_q, rf_we_q, flags_we_q;
    logic                mem_req_q, mem_we_q, mem_err_q, halted_q;
    logic                inst_we_d, pc_we_d, pc_branch_d, rf_we_d, flags_we_d;
    logic                mem_req_d, mem_we_d, mem_err_d, halted_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;

    // Next state, captured fields and next registered outputs.
    always_comb begin
        cls_d  = cls_q;
        opc_d  = opc_q;
        s_d    = s_q;
        link_d = link_q;
        cond_d = cond_q;
        // Fields are taken from the inputs only on the edge that leaves EXEC.
        if (state_q == StExec) begin
            cls_d  = inst_class;
            opc_d  = opcode;
            s_d    = s_bit;
            link_d = link_bit;
            cond_d = cond_pass;
        end

        is_dp      = (cls_d == 3'b000) || (cls_d == 3'b001);
        is_ls      = (cls_d == 3'b010);
        is_br      = (cls_d == 3'b101);
        is_test    = (opc_d >= 4'd8) && (opc_d <= 4'd11);
        mem_active = is_ls && cond_d;

        state_d = state_q;
        wait_d  = wait_q;
        timeout = 1'b0;
        case (state_q)
            // The first FETCH after reset has inst_we low, so it lingers one
            // cycle to actually latch an instruction before moving on.
            StFetch: if (inst_we_q) state_d = StExec;
            StExec: begin
                state_d = StMem;
                wait_d  = '0;
            end
            StMem: begin
                if (!mem_active || mem_ready) begin
                    state_d = StWb;
                end else if (wait_q == WaitLast) begin
                    state_d = StWb;
                    timeout = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StWb:    state_d = halt_req ? StHalt : StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase

        case (state_d)
            StExec:  phase_d = 2'b01;
            StMem:   phase_d = 2'b10;
            StWb:    phase_d = 2'b11;
            default: phase_d = 2'b00;
        endcase

        inst_we_d   = (state_d == StFetch);
        mem_req_d   = (state_d == StMem) && mem_active;
        mem_we_d    = mem_req_d && !s_d;
        pc_we_d     = (state_d == StWb);
        pc_branch_d = pc_we_d && is_br && cond_d;
        rf_we_d     = pc_we_d && cond_d &&
                      ((is_dp && !is_test) || (is_ls && s_d && !timeout) || (is_br && link_d));
        flags_we_d  = pc_we_d && is_dp && s_d && cond_d;
        halted_d    = (state_d == StHalt);
        mem_err_d   = mem_err_q | timeout;
        retired_d   = (state_q == StWb) ? retired_q + RETIRE_W'(1) : retired_q;
    end

    // Single state register for the FSM, captured fields and all outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StFetch;
            wait_q      <= '0;
            cls_q       <= '0;
            opc_q       <= '0;
            s_q         <= 1'b0;
            link_q      <= 1'b0;
            cond_q      <= 1'b0;
            phase_q     <= 2'b00;
            inst_we_q   <= 1'b0;
            pc_we_q     <= 1'b0;
            pc_branch_q <= 1'b0;
            rf_we_q     <= 1'b0;
            flags_we_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_err_q   <= 1'b0;
            halted_q    <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            cls_q       <= cls_d;
            opc_q       <= opc_d;
            s_q         <= s_d;
            link_q      <= link_d;
            cond_q      <= cond_d;
            phase_q     <= phase_d;
            inst_we_q   <= inst_we_d;
            pc_we_q     <= pc_we_d;
            pc_branch_q <= pc_branch_d;
            rf_we_q     <= rf_we_d;
            flags_we_q  <= flags_we_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_err_q   <= mem_err_d;
            halted_q    <= halted_d;
            retired_q   <= retired_d;
        end
    end

    assign phase     = phase_q;
    assign inst_we   = inst_we_q;
    assign pc_we     = pc_we_q;
    assign pc_branch = pc_branch_q;
    assign rf_we     = rf_we_q;
    assign flags_we  = flags_we_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_err   = mem_err_q;
    assign halted    = halted_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_cpu_cycle_controller.sv
// Directed bench for cpu_cycle_controller: inputs change and outputs are
// checked on the falling edge; expectations are hand-derived per cycle.
module tb_cpu_cycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  inst_class;
    logic [3:0]  opcode;
    logic        s_bit, link_bit, cond_pass, mem_ready, halt_req;
    logic [1:0]  phase;
    logic        inst_we, pc_we, pc_branch, rf_we, flags_we;
    logic        mem_req, mem_we, mem_err, halted;
    logic [15:0] retired;
    logic [10:0] outs;

    int n_cmp = 0;
    int n_bad = 0;

    // Output vector: {phase, inst_we, pc_we, pc_branch, rf_we, flags_we,
    //                 mem_req, mem_we, mem_err, halted}
    localparam logic [10:0] VF  = 11'b00_1_0_0_0_0_0_0_0_0;
    localparam logic [10:0] VE  = 11'b01_0_0_0_0_0_0_0_0_0;
    localparam logic [10:0] VM  = 11'b10_0_0_0_0_0_0_0_0_0;
    localparam logic [10:0] VW  = 11'b11_0_1_0_0_0_0_0_0_0;
    localparam logic [10:0] PB  = 11'b00_0_0_1_0_0_0_0_0_0;
    localparam logic [10:0] RW  = 11'b00_0_0_0_1_0_0_0_0_0;
    localparam logic [10:0] FW  = 11'b00_0_0_0_0_1_0_0_0_0;
    localparam logic [10:0] MR  = 11'b00_0_0_0_0_0_1_0_0_0;
    localparam logic [10:0] MW  = 11'b00_0_0_0_0_0_0_1_0_0;
    localparam logic [10:0] ME  = 11'b00_0_0_0_0_0_0_0_1_0;
    localparam logic [10:0] HL  = 11'b00_0_0_0_0_0_0_0_0_1;

    assign outs = {phase, inst_we, pc_we, pc_branch, rf_we, flags_we,
                   mem_req, mem_we, mem_err, halted};

    cpu_cycle_controller #(
        .MEM_TIMEOUT(15),
        .RETIRE_W   (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .inst_class(inst_class),
        .opcode    (opcode),
        .s_bit     (s_bit),
        .link_bit  (link_bit),
        .cond_pass (cond_pass),
        .mem_ready (mem_ready),
        .halt_req  (halt_req),
        .phase     (phase),
        .inst_we   (inst_we),
        .pc_we     (pc_we),
        .pc_branch (pc_branch),
        .rf_we     (rf_we),
        .flags_we  (flags_we),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_err   (mem_err),
        .halted    (halted),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    task automatic set_inst(input logic [2:0] cls, input logic [3:0] opc, input logic s,
                            input logic lnk, input logic cnd);
        inst_class = cls;
        opcode     = opc;
        s_bit      = s;
        link_bit   = lnk;
        cond_pass  = cnd;
    endtask

    // Advance to the next falling edge and check all outputs plus retired.
    task automatic step(input string tag, input logic [10:0] exp, input logic [15:0] exp_ret);
        @(negedge clk);
        n_cmp++;
        assert (outs === exp) else begin
            n_bad++;
            $error("FAIL %s: outs observed %b required %b", tag, outs, exp);
        end
        n_cmp++;
        assert (retired === exp_ret) else begin
            n_bad++;
            $error("FAIL %s: retired observed %0d required %0d", tag, retired, exp_ret);
        end
    endtask

    // Same as step but ignores phase, which carries no meaning in HALT.
    task automatic step_halt(input string tag, input logic [15:0] exp_ret);
        @(negedge clk);
        n_cmp++;
        assert (outs[8:0] === (ME[8:0] | HL[8:0])) else begin
            n_bad++;
            $error("FAIL %s: enables observed %b required %b", tag, outs[8:0],
                   ME[8:0] | HL[8:0]);
        end
        n_cmp++;
        assert (retired === exp_ret) else begin
            n_bad++;
            $error("FAIL %s: retired observed %0d required %0d", tag, retired, exp_ret);
        end
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        halt_req  = 1'b0;
        set_inst(3'b000, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("reset0", 11'b0, 16'd0);
        step("reset1", 11'b0, 16'd0);
        reset = 1'b0;
        step("fetch0", VF, 16'd0);

        // ADD AL, S=1; garbage on inputs after EXEC must not matter.
        set_inst(3'b000, 4'b0100, 1'b1, 1'b0, 1'b1);
        step("add_exec", VE, 16'd0);
        step("add_mem", VM, 16'd0);
        set_inst(3'b101, 4'b1111, 1'b0, 1'b1, 1'b0);
        step("add_wb", VW | RW | FW, 16'd0);
        step("add_next", VF, 16'd1);

        // CMP: flags but no register write.
        set_inst(3'b000, 4'b1010, 1'b1, 1'b0, 1'b1);
        step("cmp_exec", VE, 16'd1);
        step("cmp_mem", VM, 16'd1);
        step("cmp_wb", VW | FW, 16'd1);
        step("cmp_next", VF, 16'd2);

        // BNE failing its condition; halt pulse during EXEC is ignored.
        set_inst(3'b101, 4'b0001, 1'b0, 1'b0, 1'b0);
        step("bne_exec", VE, 16'd2);
        halt_req = 1'b1;
        step("bne_mem", VM, 16'd2);
        halt_req = 1'b0;
        step("bne_wb", VW, 16'd2);
        step("bne_next", VF, 16'd3);

        // BL taken.
        set_inst(3'b101, 4'b1000, 1'b0, 1'b1, 1'b1);
        step("bl_exec", VE, 16'd3);
        step("bl_mem", VM, 16'd3);
        step("bl_wb", VW | PB | RW, 16'd3);
        step("bl_next", VF, 16'd4);

        // LDR: early mem_ready before MEM is ignored, ready in 3rd MEM cycle.
        set_inst(3'b010, 4'b1100, 1'b1, 1'b0, 1'b1);
        mem_ready = 1'b1;
        step("ldr_exec", VE, 16'd4);
        step("ldr_mem1", VM | MR, 16'd4);
        mem_ready = 1'b0;
        set_inst(3'b000, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("ldr_mem2", VM | MR, 16'd4);
        step("ldr_mem3", VM | MR, 16'd4);
        mem_ready = 1'b1;
        step("ldr_wb", VW | RW, 16'd4);
        mem_ready = 1'b0;
        step("ldr_next", VF, 16'd5);

        // STR that never completes: 15 MEM cycles then timeout.
        set_inst(3'b010, 4'b1100, 1'b0, 1'b0, 1'b1);
        step("str_exec", VE, 16'd5);
        for (int i = 0; i < 15; i++) begin
            step($sformatf("str_mem%0d", i + 1), VM | MR | MW, 16'd5);
        end
        step("str_wb", VW | ME, 16'd5);
        step("str_next", VF | ME, 16'd6);

        // ADD with halt held through WB: commits, then HALT.
        set_inst(3'b001, 4'b0000, 1'b0, 1'b0, 1'b1);
        halt_req = 1'b1;
        step("hlt_exec", VE | ME, 16'd6);
        step("hlt_mem", VM | ME, 16'd6);
        step("hlt_wb", VW | RW | ME, 16'd6);
        step_halt("halt0", 16'd7);
        halt_req = 1'b0;
        step_halt("halt1", 16'd7);
        step_halt("halt2", 16'd7);

        // Reset leaves HALT and clears mem_err and retired.
        reset = 1'b1;
        step("rst_halt", 11'b0, 16'd0);
        reset = 1'b0;
        step("rst_fetch", VF, 16'd0);
        set_inst(3'b000, 4'b0100, 1'b0, 1'b0, 1'b1);
        step("add2_exec", VE, 16'd0);
        step("add2_mem", VM, 16'd0);
        step("add2_wb", VW | RW, 16'd0);
        step("add2_next", VF, 16'd1);

        // Reset during a pending load drops the request.
        set_inst(3'b010, 4'b1100, 1'b1, 1'b0, 1'b1);
        step("ldr2_exec", VE, 16'd1);
        step("ldr2_mem1", VM | MR, 16'd1);
        reset = 1'b1;
        step("rst_mem", 11'b0, 16'd0);
        reset = 1'b0;
        step("rst_mem_fetch", VF, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "bench timed out");
    end

endmodule
